ibex_rf_write_buffer: RTL and testbench

IBEX_RF_WRITE_BUFFER -- requirements
Module: ibex_rf_write_buffer

---
 rtl/ibex_pkg.sv | 18 +
 rtl/ibex_rf_wb_fwd.sv | 59 +++++
 rtl/ibex_rf_write_buffer.sv | 154 +++++++++++++++
 tb/tb_ibex_rf_write_buffer.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ibex_pkg.sv
// ----------------------------------------------------------------------------
// ibex_pkg
// Shared types and constants for the register-file write-back buffer.
//   RF_WB_DEPTH_DEFAULT : default number of buffered write-back entries
//   RF_WB_ADDR_W        : register index width
//   rf_wb_entry_t       : one buffered write (destination index + data)
// ----------------------------------------------------------------------------
package ibex_pkg;

    localparam int RF_WB_DEPTH_DEFAULT = 4;
    localparam int RF_WB_ADDR_W        = 5;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } rf_wb_entry_t;

endpackage

// File: rtl/ibex_rf_wb_fwd.sv
// ----------------------------------------------------------------------------
// ibex_rf_wb_fwd
// Youngest-match search over the write-buffer entries for one read port.
// Entries are visited in age order starting at the head (oldest).
// A later (younger) match overrides an earlier one, so the result reflects the
// most recent pending write to the register.
// Register x0 never hits.
// Ports:
//   head_i   : index of the oldest entry
//   valid_i  : per-entry valid bits
//   addr_i   : packed entry addresses, entry n at [n*5 +: 5]
//   data_i   : packed entry data, entry n at [n*DataWidth +: DataWidth]
//   raddr_i  : read-port address to look up
//   hit_o    : some valid entry matches raddr_i (raddr_i != 0)
//   data_o   : data of the youngest matching entry, 0 when no hit
// ----------------------------------------------------------------------------
module ibex_rf_wb_fwd #(
    parameter int  DEPTH     = 4,
    parameter int  DataWidth = 32,
    localparam int PtrW      = $clog2(DEPTH)
) (
    input  logic [PtrW-1:0]            head_i,
    input  logic [DEPTH-1:0]           valid_i,
    input  logic [DEPTH*5-1:0]         addr_i,
    input  logic [DEPTH*DataWidth-1:0] data_i,
    input  logic [4:0]                 raddr_i,
    output logic                       hit_o,
    output logic [DataWidth-1:0]       data_o
);

    logic [4:0]           addr_u   [DEPTH];
    logic [DataWidth-1:0] data_u   [DEPTH];
    logic [PtrW-1:0]      age_idx  [DEPTH];
    logic [DataWidth-1:0] data_age [DEPTH];
    logic [DEPTH-1:0]     match_age;

    // age_idx[k] is the storage slot of the k-th oldest entry
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_age
        assign addr_u[gi]    = addr_i[gi*5 +: 5];
        assign data_u[gi]    = data_i[gi*DataWidth +: DataWidth];
        assign age_idx[gi]   = head_i + PtrW'(gi);
        assign match_age[gi] = valid_i[age_idx[gi]] && (addr_u[age_idx[gi]] == raddr_i);
        assign data_age[gi]  = data_u[age_idx[gi]];
    end

    always_comb begin
        hit_o  = 1'b0;
        data_o = '0;
        if (raddr_i != 5'd0) begin
            for (int k = 0; k < DEPTH; k++) begin
                if (match_age[k]) begin
                    hit_o  = 1'b1;
                    data_o = data_age[k];
                end
            end
        end
    end

endmodule

// File: rtl/ibex_rf_write_buffer.sv
// ----------------------------------------------------------------------------
// ibex_rf_write_buffer
// Circular FIFO that decouples write-back from a register file that may stall.
// Writes to x0 are accepted and dropped.
// Entries drain in order whenever the register file is not stalling.
// Optional forwarding of pending writes to two read ports is enabled by
// defining the macro IBEX_RF_WB_FWD_EN. When the macro is undefined, the
// forwarding outputs are tied to zero.
// Ports:
//   clk_i, rst_i                      : clock, synchronous active-high reset
//   wb_valid_i/wb_ready_o             : write-back request handshake
//   wb_addr_i/wb_data_i               : write-back destination and data
//   rf_stall_i                        : register file refuses writes this cycle
//   rf_we_o/rf_waddr_o/rf_wdata_o     : register-file write port (head entry)
//   fwd_raddr_{a,b}_i                 : read addresses for forwarding lookup
//   fwd_hit_{a,b}_o/fwd_data_{a,b}_o  : forwarding result per read port
//   level_o, empty_o                  : occupancy status
// ----------------------------------------------------------------------------
module ibex_rf_write_buffer
    import ibex_pkg::*;
#(
    parameter int DEPTH     = RF_WB_DEPTH_DEFAULT,
    parameter int DataWidth = 32
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       wb_valid_i,
    output logic                       wb_ready_o,
    input  logic [4:0]                 wb_addr_i,
    input  logic [DataWidth-1:0]       wb_data_i,
    input  logic                       rf_stall_i,
    output logic                       rf_we_o,
    output logic [4:0]                 rf_waddr_o,
    output logic [DataWidth-1:0]       rf_wdata_o,
    input  logic [4:0]                 fwd_raddr_a_i,
    input  logic [4:0]                 fwd_raddr_b_i,
    output logic                       fwd_hit_a_o,
    output logic                       fwd_hit_b_o,
    output logic [DataWidth-1:0]       fwd_data_a_o,
    output logic [DataWidth-1:0]       fwd_data_b_o,
    output logic [$clog2(DEPTH):0]     level_o,
    output logic                       empty_o
);

    localparam int PtrW = $clog2(DEPTH);
    localparam int LvlW = PtrW + 1;

    logic [4:0]           addr_q [DEPTH];
    logic [DataWidth-1:0] data_q [DEPTH];
    logic [DEPTH-1:0]     valid_q, valid_d;
    logic [PtrW-1:0]      head_q, head_d;
    logic [PtrW-1:0]      tail_q, tail_d;
    logic [LvlW-1:0]      level_q, level_d;

    logic accept, push, pop;

    // Ready depends only on registered occupancy, so a full buffer refuses
    // input even if the head drains in the same cycle.
    assign wb_ready_o = (level_q != LvlW'(DEPTH));
    assign empty_o    = (level_q == '0);
    assign level_o    = level_q;

    assign accept = wb_valid_i && wb_ready_o;
    assign push   = accept && (wb_addr_i != 5'd0);
    assign pop    = rf_we_o;

    assign rf_we_o    = !empty_o && !rf_stall_i;
    assign rf_waddr_o = empty_o ? 5'd0 : addr_q[head_q];
    assign rf_wdata_o = empty_o ? '0   : data_q[head_q];

    always_comb begin
        head_d  = pop  ? head_q + 1'b1 : head_q;
        tail_d  = push ? tail_q + 1'b1 : tail_q;
        level_d = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    // When full, head and tail alias. Set must win over clear so a
    // simultaneous drain and refill keeps the slot valid.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_valid
        assign valid_d[gi] = (valid_q[gi] && !(pop && (head_q == PtrW'(gi))))
                           || (push && (tail_q == PtrW'(gi)));
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            level_q <= '0;
            valid_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            level_q <= level_d;
            valid_q <= valid_d;
        end
    end

    // Payload storage needs no reset; valid bits gate every use of it.
    always_ff @(posedge clk_i) begin
        if (push) begin
            addr_q[tail_q] <= wb_addr_i;
            data_q[tail_q] <= wb_data_i;
        end
    end

`ifdef IBEX_RF_WB_FWD_EN
    logic [DEPTH*5-1:0]         addr_flat;
    logic [DEPTH*DataWidth-1:0] data_flat;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_flat
        assign addr_flat[gi*5 +: 5]                 = addr_q[gi];
        assign data_flat[gi*DataWidth +: DataWidth] = data_q[gi];
    end

    ibex_rf_wb_fwd #(
        .DEPTH     (DEPTH),
        .DataWidth (DataWidth)
    ) u_fwd_a (
        .head_i  (head_q),
        .valid_i (valid_q),
        .addr_i  (addr_flat),
        .data_i  (data_flat),
        .raddr_i (fwd_raddr_a_i),
        .hit_o   (fwd_hit_a_o),
        .data_o  (fwd_data_a_o)
    );

    ibex_rf_wb_fwd #(
        .DEPTH     (DEPTH),
        .DataWidth (DataWidth)
    ) u_fwd_b (
        .head_i  (head_q),
        .valid_i (valid_q),
        .addr_i  (addr_flat),
        .data_i  (data_flat),
        .raddr_i (fwd_raddr_b_i),
        .hit_o   (fwd_hit_b_o),
        .data_o  (fwd_data_b_o)
    );
`else
    logic unused_fwd;
    assign unused_fwd   = ^{fwd_raddr_a_i, fwd_raddr_b_i};
    assign fwd_hit_a_o  = 1'b0;
    assign fwd_hit_b_o  = 1'b0;
    assign fwd_data_a_o = '0;
    assign fwd_data_b_o = '0;
`endif

endmodule

// File: tb/tb_ibex_rf_write_buffer.sv
// ----------------------------------------------------------------------------
// tb_ibex_rf_write_buffer
// Directed stimulus with a scoreboard.
// A model process on the rising edge tracks occupancy and enqueues each
// accepted non-x0 write.
// A monitor on the falling edge checks the status outputs every cycle.
// On every register-file write, the monitor pops the scoreboard and compares
// the address and data.
// Forwarding expectations become zero when IBEX_RF_WB_FWD_EN is undefined.
// ----------------------------------------------------------------------------
module tb_ibex_rf_write_buffer;

    localparam int DEPTH = 4;
    localparam int DW    = 32;

    logic          clk = 1'b0;
    logic          rst_i;
    logic          wb_valid_i;
    logic          wb_ready_o;
    logic [4:0]    wb_addr_i;
    logic [DW-1:0] wb_data_i;
    logic          rf_stall_i;
    logic          rf_we_o;
    logic [4:0]    rf_waddr_o;
    logic [DW-1:0] rf_wdata_o;
    logic [4:0]    fwd_raddr_a_i;
    logic [4:0]    fwd_raddr_b_i;
    logic          fwd_hit_a_o;
    logic          fwd_hit_b_o;
    logic [DW-1:0] fwd_data_a_o;
    logic [DW-1:0] fwd_data_b_o;
    logic [2:0]    level_o;
    logic          empty_o;

    ibex_rf_write_buffer #(
        .DEPTH     (DEPTH),
        .DataWidth (DW)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .wb_valid_i    (wb_valid_i),
        .wb_ready_o    (wb_ready_o),
        .wb_addr_i     (wb_addr_i),
        .wb_data_i     (wb_data_i),
        .rf_stall_i    (rf_stall_i),
        .rf_we_o       (rf_we_o),
        .rf_waddr_o    (rf_waddr_o),
        .rf_wdata_o    (rf_wdata_o),
        .fwd_raddr_a_i (fwd_raddr_a_i),
        .fwd_raddr_b_i (fwd_raddr_b_i),
        .fwd_hit_a_o   (fwd_hit_a_o),
        .fwd_hit_b_o   (fwd_hit_b_o),
        .fwd_data_a_o  (fwd_data_a_o),
        .fwd_data_b_o  (fwd_data_b_o),
        .level_o       (level_o),
        .empty_o       (empty_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]    addr;
        logic [DW-1:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   lvl_m  = 0;
    int   checks = 0;
    int   errors = 0;
    bit   en     = 1'b0;
    bit   m_drain;
    bit   m_push;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic chk_fwd(input string name, input logic hit, input logic [DW-1:0] data,
                           input logic exp_hit, input logic [DW-1:0] exp_data);
`ifndef IBEX_RF_WB_FWD_EN
        exp_hit  = 1'b0;
        exp_data = '0;
`endif
        chk({name, "_hit"},  32'(hit),  32'(exp_hit));
        chk({name, "_data"}, data, exp_data);
    endtask

    // Model: occupancy and scoreboard enqueue on each rising edge.
    always @(posedge clk) begin
        if (rst_i) begin
            exp_q.delete();
            lvl_m = 0;
        end else begin
            m_drain = (lvl_m != 0) && !rf_stall_i;
            m_push  = wb_valid_i && (lvl_m != DEPTH) && (wb_addr_i != 5'd0);
            if (m_push) begin
                exp_q.push_back('{addr: wb_addr_i, data: wb_data_i});
                lvl_m++;
            end
            if (m_drain) lvl_m--;
        end
    end

    // Monitor: per-cycle status checks and in-order write comparison.
    always @(negedge clk) begin
        if (en) begin
            chk("level", 32'(level_o), 32'(lvl_m));
            chk("ready", 32'(wb_ready_o), 32'(lvl_m != DEPTH));
            chk("empty", 32'(empty_o), 32'(lvl_m == 0));
            chk("rf_we", 32'(rf_we_o), 32'((lvl_m != 0) && !rf_stall_i));
            if (lvl_m == 0) begin
                chk("idle_waddr", 32'(rf_waddr_o), 32'd0);
                chk("idle_wdata", rf_wdata_o, 32'd0);
            end
            if (rf_we_o && !rst_i) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: actual=x%0d/0x%0h required=none",
                             rf_waddr_o, rf_wdata_o);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    $display("write x%0d = 0x%0h (expected x%0d = 0x%0h)",
                             rf_waddr_o, rf_wdata_o, e.addr, e.data);
                    chk("wr_addr", 32'(rf_waddr_o), 32'(e.addr));
                    chk("wr_data", rf_wdata_o, e.data);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [4:0] a, input logic [DW-1:0] d);
        wb_valid_i = 1'b1;
        wb_addr_i  = a;
        wb_data_i  = d;
    endtask

    task automatic idle();
        wb_valid_i = 1'b0;
        wb_addr_i  = 5'd0;
        wb_data_i  = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit done;
        rst_i         = 1'b1;
        rf_stall_i    = 1'b0;
        fwd_raddr_a_i = 5'd0;
        fwd_raddr_b_i = 5'd0;
        idle();

        // Reset state
        tick();
        en = 1'b1;
        tick();
        @(negedge clk);
        chk("rst_ready", 32'(wb_ready_o), 32'd1);
        chk("rst_we",    32'(rf_we_o),    32'd0);
        chk("rst_waddr", 32'(rf_waddr_o), 32'd0);
        chk("rst_wdata", rf_wdata_o,      32'd0);
        chk("rst_level", 32'(level_o),    32'd0);
        chk("rst_empty", 32'(empty_o),    32'd1);
        chk_fwd("rst_fwd_a", fwd_hit_a_o, fwd_data_a_o, 1'b0, 32'd0);
        chk_fwd("rst_fwd_b", fwd_hit_b_o, fwd_data_b_o, 1'b0, 32'd0);
        tick();
        rst_i = 1'b0;

        // Single write, one-cycle latency
        drive(5'd5, 32'h11);
        tick();
        idle();
        @(negedge clk);
        chk("t1_we",    32'(rf_we_o),    32'd1);
        chk("t1_waddr", 32'(rf_waddr_o), 32'd5);
        chk("t1_wdata", rf_wdata_o,      32'h11);
        tick();
        @(negedge clk);
        chk("t1_empty", 32'(empty_o), 32'd1);

        // Fill under stall, then drain in order
        tick();
        rf_stall_i = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            drive(5'(i), 32'h100 + 32'(i));
            tick();
        end
        idle();
        @(negedge clk);
        chk("t2_level", 32'(level_o),    32'd4);
        chk("t2_ready", 32'(wb_ready_o), 32'd0);
        chk("t2_we",    32'(rf_we_o),    32'd0);
        tick();
        rf_stall_i = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            chk("t2_drain_we",    32'(rf_we_o),    32'd1);
            chk("t2_drain_waddr", 32'(rf_waddr_o), 32'(k));
            tick();
        end
        @(negedge clk);
        chk("t2_empty", 32'(empty_o), 32'd1);

        // Forwarding: youngest match, x0 never hits, draining head still hits
        tick();
        rf_stall_i    = 1'b1;
        fwd_raddr_a_i = 5'd7;
        fwd_raddr_b_i = 5'd0;
        drive(5'd7, 32'hA);
        tick();
        drive(5'd7, 32'hB);
        tick();
        drive(5'd3, 32'hC);
        tick();
        idle();
        @(negedge clk);
        chk_fwd("t3_fwd_a7", fwd_hit_a_o, fwd_data_a_o, 1'b1, 32'hB);
        chk_fwd("t3_fwd_b0", fwd_hit_b_o, fwd_data_b_o, 1'b0, 32'd0);
        tick();
        fwd_raddr_b_i = 5'd3;
        @(negedge clk);
        chk_fwd("t3_fwd_b3", fwd_hit_b_o, fwd_data_b_o, 1'b1, 32'hC);
        tick();
        rf_stall_i = 1'b0;
        tick();
        tick();
        @(negedge clk);
        chk("t3_head_waddr", 32'(rf_waddr_o), 32'd3);
        chk_fwd("t3_fwd_b_head", fwd_hit_b_o, fwd_data_b_o, 1'b1, 32'hC);
        chk_fwd("t3_fwd_a_gone", fwd_hit_a_o, fwd_data_a_o, 1'b0, 32'd0);
        tick();
        @(negedge clk);
        chk_fwd("t3_fwd_b_done", fwd_hit_b_o, fwd_data_b_o, 1'b0, 32'd0);
        tick();
        fwd_raddr_a_i = 5'd0;
        fwd_raddr_b_i = 5'd0;

        // Full buffer with continuous input across pointer wrap.
        // Ready is low while full, so the first drain cycle accepts nothing.
        // Afterwards one accept and one drain occur every cycle at level 3.
        rf_stall_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(5'(8 + i), 32'h200 + 32'(i));
            tick();
        end
        rf_stall_i = 1'b0;
        for (int i = 0; i < 10; i++) begin
            drive(5'(16 + i), 32'h300 + 32'(i));
            @(negedge clk);
            chk("t4_level", 32'(level_o), (i == 0) ? 32'd4 : 32'd3);
            tick();
        end
        idle();
        done = 1'b0;
        for (int c = 0; c < 20 && !done; c++) begin
            @(negedge clk);
            if (empty_o) done = 1'b1;
            else tick();
        end
        chk("t4_drained", 32'(done), 32'd1);
        tick();

        // x0 write is consumed, then reset discards pending writes mid-stall
        drive(5'd0, 32'hFF);
        @(negedge clk);
        chk("t5_x0_ready", 32'(wb_ready_o), 32'd1);
        tick();
        idle();
        @(negedge clk);
        chk("t5_x0_level", 32'(level_o), 32'd0);
        chk("t5_x0_we",    32'(rf_we_o), 32'd0);
        tick();
        rf_stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(5'(20 + i), 32'h400 + 32'(i));
            tick();
        end
        idle();
        @(negedge clk);
        chk("t5_pre_level", 32'(level_o), 32'd3);
        tick();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        @(negedge clk);
        chk("t5_rst_level", 32'(level_o), 32'd0);
        chk("t5_rst_we",    32'(rf_we_o), 32'd0);
        chk("t5_rst_empty", 32'(empty_o), 32'd1);
        tick();
        rf_stall_i = 1'b0;
        @(negedge clk);
        chk("t5_post_we", 32'(rf_we_o), 32'd0);
        tick();

        chk("sb_leftover", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
